// File: rtl/dapa_ctrl_pkg.sv
// Shared types and constants for the DAPA2014 fetch/decode/execute sequencer.
package dapa_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_OPERAND,
      S_BRANCH,
      S_EXEC,
      S_PCSAVE,
      S_HALT,
      S_FAULT
   } state_t;

   // Opcode class, ir_opcode[7:6]
   typedef enum logic [1:0] {
      CLS_ALU1    = 2'b00,
      CLS_ALU2    = 2'b01,
      CLS_JUMP    = 2'b10,
      CLS_SPECIAL = 2'b11
   } opc_class_t;

   // Jump condition, ir_opcode[5:4]
   typedef enum logic [1:0] {
      COND_ALWAYS = 2'b00,
      COND_Z      = 2'b01,
      COND_C      = 2'b10,
      COND_NZ     = 2'b11
   } cond_t;

   localparam logic [7:0] OPC_HALT   = 8'hFF;
   localparam logic [7:0] OPC_PCSAVE = 8'hFE;

   // Outputs that depend on state only
   typedef struct packed {
      logic mem_rd;
      logic exec_start;
      logic pc_r;
      logic acc_w;
      logic halted;
      logic fault;
   } moore_t;

   function automatic logic cond_true(input logic [1:0] cond, input logic z, input logic c);
      case (cond_t'(cond))
         COND_ALWAYS: return 1'b1;
         COND_Z:      return z;
         COND_C:      return c;
         default:     return ~z;
      endcase
   endfunction

   // exec_start is left 0 here; it depends on the transition, not the state alone.
   function automatic moore_t moore_decode(input state_t s);
      moore_t o;
      o        = '0;
      o.mem_rd = (s == S_FETCH) || (s == S_OPERAND);
      o.pc_r   = (s == S_PCSAVE);
      o.acc_w  = (s == S_PCSAVE);
      o.halted = (s == S_HALT);
      o.fault  = (s == S_FAULT);
      return o;
   endfunction

endpackage

// File: rtl/pc_seq_timeout.sv
// Memory-wait counter: counts cycles spent waiting for mem_ready and flags the
// cycle in which the wait budget runs out.
module pc_seq_timeout
   import dapa_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count;

   // Count waiting cycles; restart whenever the sequencer is not stalled on memory.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of block ordering.
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   // The current cycle is the last allowed one and memory is still not ready.
   assign expired = enable && (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/decode/execute sequencer for the DAPA2014 8-bit core. Drives the PC
// strobes, the shared-bus drive enables and the memory/execute handshakes.
module pc_seq_ctrl
   import dapa_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_ready,
   input  logic [7:0] ir_opcode,
   input  logic       flag_z,
   input  logic       flag_c,
   input  logic       exec_done,
   input  logic       run,
   output logic       mem_rd,
   output logic       ir_load,
   output logic       op_load,
   output logic       op_drv,
   output logic       pc_w,
   output logic       pc_r,
   output logic       pc_i,
   output logic       acc_w,
   output logic       exec_start,
   output logic       halted,
   output logic       fault
);

   state_t state;
   state_t nxt;
   moore_t outs_q;
   moore_t outs_nxt;
   logic   waiting;
   logic   expired;
   logic   take_branch;

   assign waiting = (state == S_FETCH) || (state == S_OPERAND);

   pc_seq_timeout #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (!waiting || mem_ready),
      .enable  (waiting && !mem_ready),
      .expired (expired)
   );

   // Next-state selection and the output set that goes with it.
   always_comb begin
      // NOTE: defaults first so every path assigns every variable; no latch.
      nxt      = state;
      outs_nxt = '0;
      case (state)
         S_FETCH: begin
            if (mem_ready)    nxt = S_DECODE;
            else if (expired) nxt = S_FAULT;
         end
         S_DECODE: begin
            case (opc_class_t'(ir_opcode[7:6]))
               CLS_ALU1:           nxt = S_EXEC;
               CLS_ALU2, CLS_JUMP: nxt = S_OPERAND;
               default: begin
                  if (ir_opcode == OPC_HALT)        nxt = S_HALT;
                  else if (ir_opcode == OPC_PCSAVE) nxt = S_PCSAVE;
                  else                              nxt = S_FETCH;
               end
            endcase
         end
         S_OPERAND: begin
            if (mem_ready)    nxt = (opc_class_t'(ir_opcode[7:6]) == CLS_JUMP) ? S_BRANCH : S_EXEC;
            else if (expired) nxt = S_FAULT;
         end
         S_BRANCH, S_PCSAVE: nxt = S_FETCH;
         S_EXEC:             if (exec_done) nxt = S_FETCH;
         S_HALT, S_FAULT:    if (run) nxt = S_FETCH;
         default:            nxt = S_FETCH;
      endcase
      outs_nxt            = moore_decode(nxt);
      outs_nxt.exec_start = (nxt == S_EXEC) && (state != S_EXEC);
   end

   // State register with pre-decoded Moore outputs for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_FETCH;
         outs_q <= moore_decode(S_FETCH);
      end else begin
         state  <= nxt;
         outs_q <= outs_nxt;
      end
   end

   // Condition flags are read in the BRANCH cycle itself.
   assign take_branch = !reset && (state == S_BRANCH) && cond_true(ir_opcode[5:4], flag_z, flag_c);

   // Reset masks every output so an aborted instruction issues no strobe.
   assign mem_rd     = !reset && outs_q.mem_rd;
   assign exec_start = !reset && outs_q.exec_start;
   assign pc_r       = !reset && outs_q.pc_r;
   assign acc_w      = !reset && outs_q.acc_w;
   assign halted     = !reset && outs_q.halted;
   assign fault      = !reset && outs_q.fault;
   assign op_drv     = take_branch;
   assign pc_w       = take_branch;
   assign ir_load    = !reset && (state == S_FETCH) && mem_ready;
   assign op_load    = !reset && (state == S_OPERAND) && mem_ready;
   assign pc_i       = !reset && waiting && mem_ready;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: expected per-cycle strobes are built
// instruction by instruction from the sequencing rules (wait lengths, opcode
// class, condition, execute latency) and compared every cycle.
module tb_pc_seq_ctrl;

   localparam int MEM_TIMEOUT = 15;

   // Observation vector bit positions
   localparam logic [10:0] B_MEM_RD     = 11'h400;
   localparam logic [10:0] B_IR_LOAD    = 11'h200;
   localparam logic [10:0] B_OP_LOAD    = 11'h100;
   localparam logic [10:0] B_OP_DRV     = 11'h080;
   localparam logic [10:0] B_PC_W       = 11'h040;
   localparam logic [10:0] B_PC_R       = 11'h020;
   localparam logic [10:0] B_PC_I       = 11'h010;
   localparam logic [10:0] B_ACC_W      = 11'h008;
   localparam logic [10:0] B_EXEC_START = 11'h004;
   localparam logic [10:0] B_HALTED     = 11'h002;
   localparam logic [10:0] B_FAULT      = 11'h001;

   logic       clk;
   logic       reset;
   logic       mem_ready;
   logic [7:0] ir_opcode;
   logic       flag_z;
   logic       flag_c;
   logic       exec_done;
   logic       run;
   logic       mem_rd, ir_load, op_load, op_drv, pc_w, pc_r, pc_i, acc_w;
   logic       exec_start, halted, fault;
   logic [10:0] obs;

   int checks = 0;
   int errors = 0;
   int pc_i_cnt = 0;

   pc_seq_ctrl #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_ready  (mem_ready),
      .ir_opcode  (ir_opcode),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .exec_done  (exec_done),
      .run        (run),
      .mem_rd     (mem_rd),
      .ir_load    (ir_load),
      .op_load    (op_load),
      .op_drv     (op_drv),
      .pc_w       (pc_w),
      .pc_r       (pc_r),
      .pc_i       (pc_i),
      .acc_w      (acc_w),
      .exec_start (exec_start),
      .halted     (halted),
      .fault      (fault)
   );

   assign obs = {mem_rd, ir_load, op_load, op_drv, pc_w, pc_r, pc_i, acc_w,
                 exec_start, halted, fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic noise();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock: drive inputs, compare outputs mid-cycle, advance past the edge.
   task automatic cyc(input string tag, input logic rdy, input logic done,
                      input logic rn, input logic [10:0] exp);
      mem_ready = rdy;
      exec_done = done;
      run       = rn;
      @(negedge clk);
      check(tag, 32'(obs), 32'(exp));
      if (pc_i) pc_i_cnt++;
      @(posedge clk);
      #1;
   endtask

   // FAULT for a few cycles, left by a run pulse.
   task automatic fault_phase();
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) cyc("fault", noise(), 1'b0, 1'b0, B_FAULT);
      cyc("fault_run", noise(), 1'b0, 1'b1, B_FAULT);
   endtask

   // HALT ignores memory traffic; only run leaves it.
   task automatic halt_phase();
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) cyc("halt", 1'(i & 1), 1'b0, 1'b0, B_HALTED);
      cyc("halt_run", 1'b0, 1'b0, 1'b1, B_HALTED);
   endtask

   // Memory read that takes w idle cycles before mem_ready; too long a wait faults.
   task automatic mem_phase(input string tag, input int w, input bit is_fetch, output bit faulted);
      faulted = 1'b0;
      for (int i = 0; i < w && i < MEM_TIMEOUT; i++) cyc(tag, 1'b0, 1'b0, 1'b0, B_MEM_RD);
      if (w >= MEM_TIMEOUT) begin
         faulted = 1'b1;
         fault_phase();
      end else begin
         cyc({tag, "_ready"}, 1'b1, 1'b0, 1'b0,
             B_MEM_RD | B_PC_I | (is_fetch ? B_IR_LOAD : B_OP_LOAD));
      end
   endtask

   // Execute unit answers after lat cycles (lat=1: done with the start pulse).
   task automatic exec_phase(input int lat);
      for (int i = 0; i < lat; i++)
         cyc("exec", noise(), 1'(i == lat - 1), 1'b0, (i == 0) ? B_EXEC_START : 11'h000);
   endtask

   // Whole instruction: fetch wait w1, operand wait w2, execute latency lat.
   task automatic run_instr(input logic [7:0] opc, input int w1, input int w2,
                            input int lat, input logic z, input logic c);
      bit f;
      bit taken;
      flag_z    = z;
      flag_c    = c;
      ir_opcode = 8'($urandom);
      mem_phase("fetch", w1, 1'b1, f);
      if (f) return;
      ir_opcode = opc;
      cyc("decode", noise(), 1'b0, 1'b0, 11'h000);
      case (opc[7:6])
         2'b00: exec_phase(lat);
         2'b01: begin
            mem_phase("operand", w2, 1'b0, f);
            if (!f) exec_phase(lat);
         end
         2'b10: begin
            mem_phase("operand", w2, 1'b0, f);
            case (opc[5:4])
               2'b00:   taken = 1'b1;
               2'b01:   taken = z;
               2'b10:   taken = c;
               default: taken = !z;
            endcase
            if (!f) cyc("branch", noise(), 1'b0, 1'b0, taken ? (B_OP_DRV | B_PC_W) : 11'h000);
         end
         default: begin
            if (opc == 8'hFF)      halt_phase();
            else if (opc == 8'hFE) cyc("pcsave", noise(), 1'b0, 1'b0, B_PC_R | B_ACC_W);
         end
      endcase
   endtask

   initial begin
      int w1, w2, lat;
      logic [7:0] opc;
      reset     = 1'b1;
      mem_ready = 1'b0;
      exec_done = 1'b0;
      run       = 1'b0;
      flag_z    = 1'b0;
      flag_c    = 1'b0;
      ir_opcode = 8'h00;
      @(posedge clk);
      #1;
      // Reset state: every output low even with all inputs asserted
      cyc("reset", 1'b1, 1'b1, 1'b1, 11'h000);
      cyc("reset", 1'b1, 1'b1, 1'b1, 11'h000);
      reset = 1'b0;

      // ALU 1-byte, exec_done two cycles after start
      pc_i_cnt = 0;
      run_instr(8'h05, 0, 0, 3, 1'b0, 1'b0);
      check("h05_pc_i_count", 32'(pc_i_cnt), 32'd1);

      // Jump on Z, taken and not taken
      pc_i_cnt = 0;
      run_instr(8'h90, 0, 0, 1, 1'b1, 1'b0);
      check("jz_taken_pc_i_count", 32'(pc_i_cnt), 32'd2);
      pc_i_cnt = 0;
      run_instr(8'h90, 0, 0, 1, 1'b0, 1'b1);
      check("jz_not_taken_pc_i_count", 32'(pc_i_cnt), 32'd2);

      // PC save, HALT, NOP
      run_instr(8'hFE, 1, 0, 1, 1'b0, 1'b0);
      run_instr(8'hFF, 0, 0, 1, 1'b0, 1'b0);
      run_instr(8'hC3, 0, 0, 1, 1'b0, 1'b0);

      // Timeout boundary: 15 idle cycles fault, 14 then ready does not
      run_instr(8'h00, MEM_TIMEOUT, 0, 1, 1'b0, 1'b0);
      run_instr(8'h00, MEM_TIMEOUT - 1, 0, 1, 1'b0, 1'b0);
      run_instr(8'h41, 0, MEM_TIMEOUT, 1, 1'b0, 1'b0);
      run_instr(8'hA0, 2, MEM_TIMEOUT - 1, 1, 1'b0, 1'b1);

      // Reset held three cycles in the middle of EXEC
      ir_opcode = 8'h05;
      cyc("rst_fetch", 1'b1, 1'b0, 1'b0, B_MEM_RD | B_IR_LOAD | B_PC_I);
      cyc("rst_decode", 1'b0, 1'b0, 1'b0, 11'h000);
      cyc("rst_exec", 1'b0, 1'b0, 1'b0, B_EXEC_START);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) cyc("rst_mid_exec", 1'b1, 1'b1, 1'b1, 11'h000);
      reset = 1'b0;
      cyc("rst_release", 1'b0, 1'b0, 1'b0, B_MEM_RD);
      run_instr(8'h12, 0, 0, 2, 1'b0, 1'b0);

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         opc = 8'($urandom);
         if ($urandom_range(0, 9) == 0) opc = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hFE;
         w1  = ($urandom_range(0, 15) == 0) ? $urandom_range(12, 17) : $urandom_range(0, 3);
         w2  = ($urandom_range(0, 15) == 0) ? $urandom_range(12, 17) : $urandom_range(0, 3);
         lat = $urandom_range(1, 4);
         run_instr(opc, w1, w2, lat, noise(), noise());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
